pic_control_logic: RTL

Control and sequencing block for the 8259-style interrupt controller. It resolves priority among pending IRR requests, raises INT to the CPU, and runs the two-pulse INTA acknowledge sequence. During that sequence it sets the in-service register (ISR), clears the serviced IRR bit and emits the 8-bit vector. It also handles normal/automatic EOI and priority rotation. It sits between the IRR block, the IMR register and the CPU bus interface, and drives `highest_priority_int` back into the IRR block.

---
 rtl/pic_control_logic.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pic_control_logic.sv
// rtl/pic_control_logic.sv - 8259-style priority resolution, INTA sequencing and EOI/rotation control
module pic_control_logic #(
  parameter int VEC_BASE_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            irr,
  input  logic [7:0]            imr,
  input  logic                  inta,
  input  logic                  eoi,
  input  logic                  eoi_specific,
  input  logic [2:0]            eoi_level,
  input  logic                  aeoi,
  input  logic                  rotate,
  input  logic [VEC_BASE_W-1:0] vector_base,
  output logic                  int_out,
  output logic [7:0]            clr_irr,
  output logic [7:0]            isr,
  output logic [7:0]            vector,
  output logic                  vector_valid,
  output logic [2:0]            highest_priority_int
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_ACK2 = 2'd2;

  logic [1:0] state;
  logic [2:0] sel;
  logic       spurious;

  logic [7:0] req;
  logic [2:0] scan_lvl;
  logic       cand_found;
  logic [2:0] cand_level;
  logic [2:0] cand_rank;
  logic       top_found;
  logic [2:0] top_level;
  logic [2:0] top_rank;
  logic       eligible;

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    req        = irr & ~imr;
    scan_lvl   = '0;
    cand_found = 1'b0;
    cand_level = '0;
    cand_rank  = '0;
    top_found  = 1'b0;
    top_level  = '0;
    top_rank   = '0;
    for (int r = 7; r >= 0; r--) begin
      scan_lvl = highest_priority_int + 3'(r);
      if (req[scan_lvl]) begin
        cand_found = 1'b1;
        cand_level = scan_lvl;
        cand_rank  = 3'(r);
      end
      if (isr[scan_lvl]) begin
        top_found = 1'b1;
        top_level = scan_lvl;
        top_rank  = 3'(r);
      end
    end
    eligible = cand_found && (!top_found || (cand_rank < top_rank));
  end

  logic       ack1;
  logic       ack2;
  logic       aeoi_clr;
  logic       eoi_hit;
  logic [2:0] eoi_target;
  logic [7:0] isr_set;
  logic [7:0] isr_clr;

  // EOI targets come from the pre-update isr, so they compose with a same-cycle set.
  always_comb begin
    ack1       = (state == ST_PEND) && inta;
    ack2       = (state == ST_ACK2) && inta;
    aeoi_clr   = ack2 && aeoi && !spurious;
    eoi_target = eoi_specific ? eoi_level : top_level;
    eoi_hit    = eoi && isr[eoi_target];
    isr_set    = (ack1 && eligible) ? (8'd1 << cand_level) : 8'd0;
    isr_clr    = '0;
    if (eoi_hit) isr_clr[eoi_target] = 1'b1;
    if (aeoi_clr) isr_clr[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= ST_IDLE;
      sel                  <= '0;
      spurious             <= 1'b0;
      int_out              <= 1'b0;
      clr_irr              <= '0;
      isr                  <= '0;
      vector               <= '0;
      vector_valid         <= 1'b0;
      highest_priority_int <= '0;
    end else begin
      clr_irr      <= isr_set;
      vector_valid <= 1'b0;
      isr          <= (isr | isr_set) & ~isr_clr;
      if (rotate) begin
        if (aeoi_clr) highest_priority_int <= sel + 3'd1;
        else if (eoi_hit) highest_priority_int <= eoi_target + 3'd1;
      end
      case (state)
        ST_IDLE: begin
          if (eligible) begin
            state   <= ST_PEND;
            int_out <= 1'b1;
          end
        end
        ST_PEND: begin
          if (inta) begin
            state    <= ST_ACK2;
            int_out  <= 1'b0;
            spurious <= !eligible;
            sel      <= eligible ? cand_level : 3'd7;
          end else if (!eligible) begin
            state   <= ST_IDLE;
            int_out <= 1'b0;
          end
        end
        ST_ACK2: begin
          if (inta) begin
            state        <= ST_IDLE;
            vector       <= 8'({vector_base, sel});
            vector_valid <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          int_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
